seg_scan_capture: RTL and testbench
===================================

# seg_scan_capture

Passive receiver for the multiplexed seven-segment bus (`ANODE`/`SEG`/`DECIMAL_P`) driven by the display scan path. It samples the scanned digits, inverts the hex-to-segment encoding, and rebuilds the four displayed digits as a coherent frame. It sits beside the display output as a hardware readback monitor for self-check and for simulation scoreboards. Blink blanking, illegal anode states and unknown segment patterns are flagged, never silently decoded.

## Interface
Parameters:
- SETTLE_CYCLES, 16, consecutive identical registered samples required before a digit is captured (1..255).
- TIMEOUT_CYCLES, 2_000_000, cycles without any capture before `stale` asserts.

Ports:
- clock  in  1  system clock; single clock domain, shared with the display scan logic.
- reset  in  1  synchronous, active-high.
- anode  in  4  scanned anode bus; active-low; bit k selects digit k, where digit 3 is minutes and digit 0 is tenths.
- seg  in  7  segment bus; active-low; seg[0]=a … seg[6]=g.
- decimal_p  in  1  decimal point; active-low.
- digit3, digit2, digit1, digit0  out  4 each  last complete frame, decoded hex.
- dp_mask  out  4  bit k=1 when the DP was lit on digit k in the last frame.
- blank_mask  out  4  bit k=1 when digit k was selected with all segments off.
- frame_valid  out  1  one-cycle pulse when the digit/mask outputs update.
- pattern_error  out  1  one-cycle pulse on an illegal anode or an undecodable segment pattern.
- stale  out  1  level; high when no capture has occurred for TIMEOUT_CYCLES.

## Operation
- Input stage: `anode`, `seg` and `decimal_p` are registered once. All further logic uses the registered copies.
- The anode is legal-active when exactly one bit is 0. All-ones means idle or blanked and is not an error. Two or more zeros is illegal.
- FSM states:
  - IDLE: wait for legal-active anode, clear the settle counter, then go to SETTLE.
  - SETTLE: count cycles while anode, seg and dp are unchanged. Any change restarts the count. An anode that goes all-ones returns to IDLE. When the count reaches SETTLE_CYCLES, go to CAPTURE.
  - CAPTURE: one cycle. Write the shadow digit, dp and blank entries for the selected index, set seen[k], then go to HOLD.
  - HOLD: wait for the anode to change. Legal-active goes to SETTLE; all-ones goes to IDLE.
- Illegal anode in any state: pulse `pattern_error`, go to IDLE, leave `seen` unchanged.
- Decoding: seg must match one of the 16 hex codes exactly, or be all-ones, which means blank. Blank gives digit value 0 and sets the blank bit. Any other pattern pulses `pattern_error` in CAPTURE, writes nothing, and leaves seen[k] unchanged.
- Frame: when `seen` becomes 4'b1111, all shadow registers are copied to the outputs, `frame_valid` pulses, and `seen` clears. Recapturing a digit before the frame completes overwrites its shadow entry. Outputs never mix two frames.
- Timeout counter:
  - Clears on every CAPTURE and saturates at TIMEOUT_CYCLES.
  - `stale` = (counter == TIMEOUT_CYCLES).
  - `stale` clears on the cycle `frame_valid` pulses.
- Reset values: digit3..digit0 = 0, dp_mask = 0, blank_mask = 0, frame_valid = 0, pattern_error = 0, stale = 1, seen = 0, FSM = IDLE. Reset mid-capture discards the shadow registers.

## Timing
- A bus change at edge t appears registered at t+1. CAPTURE occurs at t+1+SETTLE_CYCLES.
- `frame_valid` and the output update occur on the edge after the fourth CAPTURE, so latency is 1 cycle from that CAPTURE.
- `pattern_error` for an illegal anode asserts 1 cycle after the registered illegal value. For a bad pattern it asserts in the CAPTURE cycle.
- If a digit is held for fewer than SETTLE_CYCLES+1 cycles, it is never captured. This is the required ghost rejection.
- `stale` rises exactly TIMEOUT_CYCLES cycles after the last CAPTURE.

## Structure
- Package `seg_pkg` holds:
  - SEG_HEX[0:15]: active-low codes, for example 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000, F = 7'b0001110.
  - SEG_BLANK = 7'b1111111 and ANODE_IDLE = 4'b1111.
  - The FSM state enum.
- One sub-module, `seg_pattern_decode`: combinational seg → {hex[3:0], is_blank, is_valid}. It shares SEG_HEX with the forward decoder so the two cannot drift.

## Test plan
- Scan digits 3..0 with values 1,2,3,4, 40 cycles each, all DP off, SETTLE_CYCLES=16 → one `frame_valid`; digit3..0 = 1,2,3,4; dp_mask = 0; blank_mask = 0; `stale` falls on the same cycle.
- Hold a digit for only 10 cycles, then scan the remaining three normally → no `frame_valid` until that digit is rescanned for ≥17 cycles.
- Drive anode 4'b1010 → one `pattern_error` pulse; FSM returns to IDLE; outputs unchanged.
- Send seg 7'b0110110 on digit 2 → `pattern_error` pulses in CAPTURE; seen[2] stays 0; no frame completes.
- Hold anode all-ones for TIMEOUT_CYCLES (override to 100) → `stale` rises at cycle 100 after the last capture. Assert reset mid-SETTLE → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan bus: active-low hex codes, idle/blank patterns,
// the capture FSM state type and small anode helpers.
package seg_pkg;

    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [3:0] ANODE_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCapture,
        StHold
    } scan_state_e;

    // Forward encoder used by the display side; the decoder inverts the same table.
    function automatic logic [6:0] seg_encode(input logic [3:0] hex);
        return SEG_HEX[hex];
    endfunction

    function automatic logic [2:0] anode_zeros(input logic [3:0] a);
        logic [2:0] n;
        n = '0;
        for (int k = 0; k < 4; k++) begin
            if (!a[k]) n = n + 3'd1;
        end
        return n;
    endfunction

    function automatic logic [1:0] anode_index(input logic [3:0] a);
        logic [1:0] idx;
        idx = '0;
        for (int k = 0; k < 4; k++) begin
            if (!a[k]) idx = 2'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Inverse of the hex-to-segment encoder: maps an active-low segment pattern back to its hex
// value, flagging blank (all segments off) and any pattern outside the table.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       is_blank,
    output logic       is_valid
);

    always_comb begin
        hex      = '0;
        is_blank = (seg == SEG_BLANK);
        is_valid = is_blank;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_HEX[i]) begin
                hex      = 4'(i);
                is_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Passive readback monitor for the multiplexed seven-segment bus: settles and captures each
// scanned digit, then publishes all four as one coherent frame.
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] anode,
    input  logic [6:0] seg,
    input  logic       decimal_p,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic [3:0] dp_mask,
    output logic [3:0] blank_mask,
    output logic       frame_valid,
    output logic       pattern_error,
    output logic       stale
);

    localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [7:0]       SETTLE_N = 8'(SETTLE_CYCLES);

    logic [3:0]       anode_r, anode_prev, snap_anode;
    logic [6:0]       seg_r, snap_seg;
    logic             dp_r, snap_dp;
    scan_state_e      state;
    logic [7:0]       cnt;
    logic [3:0]       seen;
    logic [3:0][3:0]  sh_digit, out_digit, merged_digit;
    logic [3:0]       sh_dp, sh_blank, merged_dp, merged_blank;
    logic [TMO_W-1:0] tmo;
    logic             boot_stale;

    logic [3:0] dec_hex;
    logic       dec_blank, dec_valid;
    logic       anode_idle, anode_active, anode_illegal;
    logic       bus_same, settle_hits, want_start, want_enter;
    logic [1:0] sel;
    logic [3:0] sel_oh;

    // Decodes the live registered sample; on every path that uses it, it equals the snapshot.
    seg_pattern_decode u_decode (
        .seg      (seg_r),
        .hex      (dec_hex),
        .is_blank (dec_blank),
        .is_valid (dec_valid)
    );

    always_comb begin
        anode_idle    = (anode_r == ANODE_IDLE);
        anode_active  = (anode_zeros(anode_r) == 3'd1);
        anode_illegal = !anode_idle && !anode_active;
        bus_same      = (anode_r == snap_anode) && (seg_r == snap_seg) && (dp_r == snap_dp);
        settle_hits   = ({1'b0, cnt} + 9'd1) >= {1'b0, SETTLE_N};
        want_start    = anode_active &&
                        ((state == StIdle) ||
                         (state == StHold && anode_r != snap_anode) ||
                         ((state == StSettle || state == StCapture) && !bus_same));
        want_enter    = want_start ? (SETTLE_N <= 8'd1)
                                   : (state == StSettle && bus_same && settle_hits);
        sel           = anode_index(snap_anode);
        sel_oh        = ~snap_anode;
        merged_digit       = sh_digit;
        merged_dp          = sh_dp;
        merged_blank       = sh_blank;
        merged_digit[sel]  = dec_hex;
        merged_dp[sel]     = ~dp_r;
        merged_blank[sel]  = dec_blank;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            anode_r       <= ANODE_IDLE;
            anode_prev    <= ANODE_IDLE;
            seg_r         <= SEG_BLANK;
            dp_r          <= 1'b1;
            snap_anode    <= ANODE_IDLE;
            snap_seg      <= SEG_BLANK;
            snap_dp       <= 1'b1;
            state         <= StIdle;
            cnt           <= '0;
            seen          <= '0;
            sh_digit      <= '0;
            sh_dp         <= '0;
            sh_blank      <= '0;
            out_digit     <= '0;
            dp_mask       <= '0;
            blank_mask    <= '0;
            frame_valid   <= 1'b0;
            pattern_error <= 1'b0;
            tmo           <= TMO_MAX;
            boot_stale    <= 1'b1;
        end else begin
            anode_r       <= anode;
            seg_r         <= seg;
            dp_r          <= decimal_p;
            anode_prev    <= anode_r;
            frame_valid   <= 1'b0;
            pattern_error <= 1'b0;
            if (tmo != TMO_MAX) tmo <= tmo + TMO_W'(1);

            if (anode_illegal) begin
                // Flag only the first cycle of an illegal value, not every cycle it persists.
                pattern_error <= (anode_r != anode_prev);
                state         <= StIdle;
            end else if (anode_idle) begin
                state <= StIdle;
            end else begin
                if (want_start) begin
                    snap_anode <= anode_r;
                    snap_seg   <= seg_r;
                    snap_dp    <= dp_r;
                    cnt        <= 8'd1;
                end
                if (want_enter) begin
                    state         <= StCapture;
                    tmo           <= '0;
                    pattern_error <= !dec_valid;
                end else if (want_start) begin
                    state <= StSettle;
                end else begin
                    case (state)
                        StSettle: cnt <= cnt + 8'd1;
                        StCapture: begin
                            // The cycle in CAPTURE is the final stability sample.
                            state <= StHold;
                            if (dec_valid) begin
                                sh_digit <= merged_digit;
                                sh_dp    <= merged_dp;
                                sh_blank <= merged_blank;
                                if ((seen | sel_oh) == 4'b1111) begin
                                    out_digit   <= merged_digit;
                                    dp_mask     <= merged_dp;
                                    blank_mask  <= merged_blank;
                                    frame_valid <= 1'b1;
                                    seen        <= '0;
                                    boot_stale  <= 1'b0;
                                end else begin
                                    seen <= seen | sel_oh;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign digit3 = out_digit[3];
    assign digit2 = out_digit[2];
    assign digit1 = out_digit[1];
    assign digit0 = out_digit[0];
    // Stale from reset until the first full frame, afterwards purely from the capture timer.
    assign stale  = boot_stale || (tmo == TMO_MAX);

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: frame assembly, ghost rejection, illegal anode,
// bad segment pattern, stale timing and mid-settle reset.
module tb_seg_scan_capture;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] anode = 4'b1111;
    logic [6:0] seg = 7'b1111111;
    logic       decimal_p = 1'b1;
    logic [3:0] digit3, digit2, digit1, digit0, dp_mask, blank_mask;
    logic       frame_valid, pattern_error, stale;

    seg_scan_capture #(
        .SETTLE_CYCLES  (16),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .anode         (anode),
        .seg           (seg),
        .decimal_p     (decimal_p),
        .digit3        (digit3),
        .digit2        (digit2),
        .digit1        (digit1),
        .digit0        (digit0),
        .dp_mask       (dp_mask),
        .blank_mask    (blank_mask),
        .frame_valid   (frame_valid),
        .pattern_error (pattern_error),
        .stale         (stale)
    );

    always #5 clock = ~clock;

    localparam logic [3:0] AN3 = 4'b0111, AN2 = 4'b1011, AN1 = 4'b1101, AN0 = 4'b1110;
    localparam logic [3:0] AN_IDLE = 4'b1111;
    localparam logic [6:0] C0 = 7'h40, C1 = 7'h79, C2 = 7'h24, C3 = 7'h30, C4 = 7'h19;
    localparam logic [6:0] C5 = 7'h12, C6 = 7'h02, C7 = 7'h78, C8 = 7'h00, C9 = 7'h10;
    localparam logic [6:0] CA = 7'h08, CC = 7'h46, CD = 7'h21, CE = 7'h06, CF = 7'h0E;
    localparam logic [6:0] BLANK = 7'h7F, BAD = 7'b0110110;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int start_cyc = 0;
    int fv_count = 0, fv_cyc = -1;
    int pe_count = 0, pe_cyc = -1;
    int stale_rise_cyc = -1;
    logic stale_at_fv = 1'b1, stale_before_fv = 1'b0, prev_stale = 1'b1;

    // Event monitor, sampled 1 time unit after each rising edge.
    always @(posedge clock) begin
        #1;
        cyc++;
        if (frame_valid) begin
            fv_count++;
            fv_cyc          = cyc;
            stale_at_fv     = stale;
            stale_before_fv = prev_stale;
        end
        if (pattern_error) begin
            pe_count++;
            pe_cyc = cyc;
        end
        if (stale && !prev_stale) stale_rise_cyc = cyc;
        prev_stale = stale;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic dp, input int n);
        anode     = a;
        seg       = s;
        decimal_p = dp;
        start_cyc = cyc;
        repeat (n) @(negedge clock);
    endtask

    task automatic chk_frame(input string tag, input int d3, input int d2, input int d1,
                             input int d0, input int dpm, input int blm);
        chk({tag, ".digit3"}, int'(digit3), d3);
        chk({tag, ".digit2"}, int'(digit2), d2);
        chk({tag, ".digit1"}, int'(digit1), d1);
        chk({tag, ".digit0"}, int'(digit0), d0);
        chk({tag, ".dp_mask"}, int'(dp_mask), dpm);
        chk({tag, ".blank_mask"}, int'(blank_mask), blm);
    endtask

    initial begin
        int mark, fv_before, pe_before;

        repeat (3) @(negedge clock);
        chk_frame("reset", 0, 0, 0, 0, 0, 0);
        chk("reset.frame_valid", int'(frame_valid), 0);
        chk("reset.pattern_error", int'(pattern_error), 0);
        chk("reset.stale", int'(stale), 1);
        reset = 1'b0;

        // Frame 1: 1,2,3,4 with DP off
        hold(AN3, C1, 1'b1, 40);
        hold(AN2, C2, 1'b1, 40);
        hold(AN1, C3, 1'b1, 40);
        hold(AN0, C4, 1'b1, 40);
        mark = start_cyc;
        chk("f1.count", fv_count, 1);
        chk("f1.latency", fv_cyc, mark + 18);
        chk("f1.stale_at_fv", int'(stale_at_fv), 0);
        chk("f1.stale_before_fv", int'(stale_before_fv), 1);
        chk_frame("f1", 1, 2, 3, 4, 0, 0);
        chk("f1.no_error", pe_count, 0);

        // Frame 2: DP on digits 3 and 0, digit 2 blank
        hold(AN3, CA, 1'b0, 40);
        hold(AN2, BLANK, 1'b1, 40);
        hold(AN1, CF, 1'b1, 40);
        hold(AN0, C8, 1'b0, 40);
        chk("f2.count", fv_count, 2);
        chk_frame("f2", 10, 0, 15, 8, 4'b1001, 4'b0100);

        // Ghost rejection: 10-cycle digit3, then 16-cycle digit3, then 17-cycle digit3
        hold(AN3, C5, 1'b1, 10);
        hold(AN2, C6, 1'b1, 40);
        hold(AN1, C7, 1'b1, 40);
        hold(AN0, C9, 1'b1, 40);
        chk("ghost10.no_frame", fv_count, 2);
        hold(AN3, C5, 1'b1, 16);
        hold(AN_IDLE, BLANK, 1'b1, 5);
        chk("ghost16.no_frame", fv_count, 2);
        hold(AN3, C5, 1'b1, 17);
        mark = start_cyc;
        hold(AN_IDLE, BLANK, 1'b1, 5);
        chk("ghost17.frame", fv_count, 3);
        chk("ghost17.latency", fv_cyc, mark + 18);
        chk_frame("f3", 5, 6, 7, 9, 0, 0);

        // Illegal anode
        pe_before = pe_count;
        fv_before = fv_count;
        hold(4'b1010, C0, 1'b1, 5);
        mark = start_cyc;
        hold(AN_IDLE, BLANK, 1'b1, 5);
        chk("illegal.one_pulse", pe_count, pe_before + 1);
        chk("illegal.timing", pe_cyc, mark + 2);
        chk("illegal.no_frame", fv_count, fv_before);
        chk_frame("illegal.unchanged", 5, 6, 7, 9, 0, 0);

        // Undecodable pattern on digit 2
        hold(AN2, BAD, 1'b1, 40);
        mark = start_cyc;
        chk("badseg.one_pulse", pe_count, pe_before + 2);
        chk("badseg.timing", pe_cyc, mark + 17);
        hold(AN3, C0, 1'b1, 40);
        hold(AN1, CC, 1'b0, 40);
        hold(AN0, CD, 1'b1, 40);
        hold(AN_IDLE, BLANK, 1'b1, 5);
        chk("badseg.seen2_clear", fv_count, 3);
        hold(AN2, CE, 1'b1, 40);
        chk("badseg.completed", fv_count, 4);
        chk_frame("f4", 0, 14, 12, 13, 4'b0010, 0);

        // Stale: idle bus after the last capture
        chk("stale.low_after_frame", int'(stale), 0);
        hold(AN_IDLE, BLANK, 1'b1, 105);
        chk("stale.rise_cycle", stale_rise_cyc, fv_cyc + 99);
        chk("stale.level", int'(stale), 1);

        // Reset mid-settle discards shadows and seen
        hold(AN3, C1, 1'b1, 40);
        hold(AN2, C2, 1'b1, 40);
        hold(AN1, C3, 1'b1, 5);
        reset = 1'b1;
        @(negedge clock);
        chk_frame("midreset", 0, 0, 0, 0, 0, 0);
        chk("midreset.frame_valid", int'(frame_valid), 0);
        chk("midreset.pattern_error", int'(pattern_error), 0);
        chk("midreset.stale", int'(stale), 1);
        reset = 1'b0;
        fv_before = fv_count;
        hold(AN1, C3, 1'b1, 40);
        hold(AN0, C4, 1'b1, 40);
        hold(AN_IDLE, BLANK, 1'b1, 5);
        chk("midreset.seen_cleared", fv_count, fv_before);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
